rsa_keygen_ctrl: RTL and testbench

- Top-level sequencer for RSA key generation.
- Obtains two distinct 16-bit primes from the prime source, then time-shares one external multiplier to form n = p*q and phi = (p-1)*(q-1).
- Runs the E-key generator (Euclid/GCD engine) on phi, then the D-key (modular inverse) engine.
- Presents n, e, d with a done pulse, or an error flag on timeout or retry exhaustion.

---
 rtl/rsa_keygen_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_rsa_keygen_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_keygen_ctrl.sv
// Sequencer for RSA key generation: prime fetch, shared multiplier, E/D engines.
// Optional build macro KEYGEN_FIXED_E_EN: use e = 65537 directly when phi > 65537.
module rsa_keygen_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES  = 4096,
   parameter int unsigned MAX_PRIME_RETRY = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] seed,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] n_key,
   output logic [31:0] e_key,
   output logic [31:0] d_key,
   output logic        prime_req,
   input  logic        prime_valid,
   input  logic [15:0] prime_data,
   output logic        mul_start,
   output logic [15:0] mul_a,
   output logic [15:0] mul_b,
   input  logic        mul_valid,
   input  logic [31:0] mul_result,
   output logic        e_en,
   output logic [31:0] e_seed,
   output logic [31:0] e_phi,
   input  logic        e_valid,
   input  logic [31:0] e_key_in,
   output logic        d_start,
   output logic [31:0] d_e,
   output logic [31:0] d_phi,
   input  logic        d_valid,
   input  logic [31:0] d_key_in
);

   typedef enum logic [3:0] {
      IDLE, GET_P, GET_Q, MUL_N, WAIT_N, MUL_PHI, WAIT_PHI,
      E_GEN, D_START, D_WAIT, DONE, ERROR
   } state_t;

   localparam logic [31:0] FIXED_E = 32'd65537;

   state_t      state, state_nx;
   logic [31:0] seed_r;
   logic [15:0] p_r, q_r;
   logic [31:0] n_r, phi_r, e_r;
   logic [31:0] retry_cnt;
   logic [31:0] timer;
   logic [31:0] retry_inc;
   logic        start_ok;
   logic        timed_out;
   logic        dup_prime;
   logic        timer_run;

   assign retry_inc = retry_cnt + 32'd1;
   assign start_ok  = start && (state == IDLE || state == DONE || state == ERROR);
   assign timed_out = (timer == TIMEOUT_CYCLES - 32'd1);
   assign dup_prime = (prime_data == p_r);
   assign timer_run = (state == GET_P) || (state == GET_Q) || (state == WAIT_N) ||
                      (state == WAIT_PHI) || (state == E_GEN) || (state == D_WAIT);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: an awaited valid always takes priority over the timeout.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (start_ok) state_nx = GET_P;
         GET_P: begin
            if (prime_valid)    state_nx = GET_Q;
            else if (timed_out) state_nx = ERROR;
         end
         GET_Q: begin
            if (prime_valid) begin
               if (!dup_prime)                           state_nx = MUL_N;
               else if (retry_inc == MAX_PRIME_RETRY)    state_nx = ERROR;
            end else if (timed_out) begin
               state_nx = ERROR;
            end
         end
         MUL_N:    state_nx = WAIT_N;
         WAIT_N: begin
            if (mul_valid)      state_nx = MUL_PHI;
            else if (timed_out) state_nx = ERROR;
         end
         MUL_PHI:  state_nx = WAIT_PHI;
         WAIT_PHI: begin
            if (mul_valid) begin
`ifdef KEYGEN_FIXED_E_EN
               if (mul_result > FIXED_E) state_nx = D_START;
               else                      state_nx = E_GEN;
`else
               state_nx = E_GEN;
`endif
            end else if (timed_out) begin
               state_nx = ERROR;
            end
         end
         E_GEN: begin
            if (e_valid)        state_nx = D_START;
            else if (timed_out) state_nx = ERROR;
         end
         D_START:  state_nx = D_WAIT;
         D_WAIT: begin
            if (d_valid)        state_nx = DONE;
            else if (timed_out) state_nx = ERROR;
         end
         DONE:     state_nx = start_ok ? GET_P : IDLE;
         ERROR:    if (start_ok) state_nx = GET_P;
         default:  state_nx = IDLE;
      endcase
   end

   // Wait-state timer restarts whenever the state changes.
   always_ff @(posedge clk) begin
      if (rst)                    timer <= '0;
      else if (state_nx != state) timer <= '0;
      else if (timer_run)         timer <= timer + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seed_r    <= '0;
         p_r       <= '0;
         q_r       <= '0;
         n_r       <= '0;
         phi_r     <= '0;
         e_r       <= '0;
         retry_cnt <= '0;
         n_key     <= '0;
         e_key     <= '0;
         d_key     <= '0;
      end else begin
         if (start_ok) begin
            seed_r    <= seed;
            retry_cnt <= '0;
            n_key     <= '0;
            e_key     <= '0;
            d_key     <= '0;
         end
         case (state)
            GET_P:    if (prime_valid) p_r <= prime_data;
            GET_Q: begin
               if (prime_valid) begin
                  if (dup_prime) retry_cnt <= retry_inc;
                  else           q_r       <= prime_data;
               end
            end
            WAIT_N:   if (mul_valid) n_r <= mul_result;
            WAIT_PHI: begin
               if (mul_valid) begin
                  phi_r <= mul_result;
`ifdef KEYGEN_FIXED_E_EN
                  if (mul_result > FIXED_E) e_r <= FIXED_E;
`endif
               end
            end
            E_GEN:    if (e_valid) e_r <= e_key_in;
            // Keys become visible on entry to DONE, alongside the done pulse.
            D_WAIT: begin
               if (d_valid) begin
                  n_key <= n_r;
                  e_key <= e_r;
                  d_key <= d_key_in;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      prime_req = 1'b0;
      mul_start = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      e_en      = 1'b0;
      e_seed    = '0;
      e_phi     = '0;
      d_start   = 1'b0;
      d_e       = '0;
      d_phi     = '0;
      case (state)
         IDLE:    busy = 1'b0;
         GET_P,
         GET_Q:   prime_req = 1'b1;
         MUL_N: begin
            mul_start = 1'b1;
            mul_a     = p_r;
            mul_b     = q_r;
         end
         MUL_PHI: begin
            mul_start = 1'b1;
            mul_a     = p_r - 16'd1;
            mul_b     = q_r - 16'd1;
         end
         E_GEN: begin
            e_en   = 1'b1;
            e_seed = seed_r;
            e_phi  = phi_r;
         end
         D_START: begin
            d_start = 1'b1;
            d_e     = e_r;
            d_phi   = phi_r;
         end
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         ERROR: begin
            busy  = 1'b0;
            error = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Scoreboard bench for rsa_keygen_ctrl with prime, multiplier, E and D stubs.
module tb_rsa_keygen_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] seed = '0;
   logic        busy, done, error;
   logic [31:0] n_key, e_key, d_key;
   logic        prime_req;
   logic        prime_valid = 1'b0;
   logic [15:0] prime_data = '0;
   logic        mul_start;
   logic [15:0] mul_a, mul_b;
   logic        mul_valid = 1'b0;
   logic [31:0] mul_result = '0;
   logic        e_en;
   logic [31:0] e_seed, e_phi;
   logic        e_valid = 1'b0;
   logic [31:0] e_key_in = '0;
   logic        d_start;
   logic [31:0] d_e, d_phi;
   logic        d_valid = 1'b0;
   logic [31:0] d_key_in = '0;

   rsa_keygen_ctrl #(.TIMEOUT_CYCLES(64), .MAX_PRIME_RETRY(2)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed),
      .busy(busy), .done(done), .error(error),
      .n_key(n_key), .e_key(e_key), .d_key(d_key),
      .prime_req(prime_req), .prime_valid(prime_valid), .prime_data(prime_data),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_valid(mul_valid), .mul_result(mul_result),
      .e_en(e_en), .e_seed(e_seed), .e_phi(e_phi),
      .e_valid(e_valid), .e_key_in(e_key_in),
      .d_start(d_start), .d_e(d_e), .d_phi(d_phi),
      .d_valid(d_valid), .d_key_in(d_key_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          err;
      logic [31:0] n, e, d;
      int          lat;
   } res_t;

   logic [15:0] prime_q[$];
   logic [31:0] exp_mul[$];
   logic [63:0] exp_e[$];
   logic [63:0] exp_d[$];
   res_t        exp_res[$];

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int prime_used = 0;
   bit e_mute = 0, d_mute = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Prime source: one prime per cycle while requested.
   initial forever begin
      @(negedge clk);
      prime_valid = 1'b0;
      if (prime_req && prime_q.size() > 0) begin
         prime_valid = 1'b1;
         prime_data  = prime_q.pop_front();
         prime_used++;
      end
   end

   // Multiplier: result three cycles after the operand strobe.
   initial begin
      int m_cnt;
      logic [31:0] m_res;
      m_cnt = 0; m_res = '0;
      forever begin
         @(negedge clk);
         mul_valid = 1'b0;
         if (mul_start) begin
            m_cnt = 3;
            m_res = 32'(mul_a) * 32'(mul_b);
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               mul_valid  = 1'b1;
               mul_result = m_res;
            end
         end
      end
   end

   initial begin
      int e_cnt;
      e_cnt = 0;
      forever begin
         @(negedge clk);
         e_valid = 1'b0;
         if (e_en && !e_mute) begin
            e_cnt++;
            if (e_cnt == 3) begin
               e_valid  = 1'b1;
               e_key_in = 32'd17;
            end
         end else begin
            e_cnt = 0;
         end
      end
   end

   initial begin
      int d_cnt;
      d_cnt = 0;
      forever begin
         @(negedge clk);
         d_valid = 1'b0;
         if (d_start && !d_mute) begin
            d_cnt = 3;
         end else if (d_cnt > 0) begin
            d_cnt--;
            if (d_cnt == 0) begin
               d_valid  = 1'b1;
               d_key_in = 32'd2753;
            end
         end
      end
   end

   // Monitor: pops an expectation whenever the DUT presents a strobe or result.
   initial begin
      logic e_en_q, error_q;
      int   e_cyc;
      res_t r;
      e_en_q = 0; error_q = 0; e_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mul_start) begin
               chk("mul_expected", 64'(exp_mul.size() != 0), 64'd1);
               if (exp_mul.size() != 0) chk("mul_operands", {mul_a, mul_b}, exp_mul.pop_front());
            end
            if (e_en && !e_en_q) begin
               e_cyc = cyc;
               chk("e_en_expected", 64'(exp_e.size() != 0), 64'd1);
               if (exp_e.size() != 0) chk("e_seed_phi", {e_seed, e_phi}, exp_e.pop_front());
            end
            if (d_start) begin
               chk("d_start_expected", 64'(exp_d.size() != 0), 64'd1);
               if (exp_d.size() != 0) chk("d_e_phi", {d_e, d_phi}, exp_d.pop_front());
            end
            if (done || (error && !error_q)) begin
               chk("result_expected", 64'(exp_res.size() != 0), 64'd1);
               if (exp_res.size() != 0) begin
                  r = exp_res.pop_front();
                  chk("result_kind_error", 64'(error), 64'(r.err));
                  chk("n_key", 64'(n_key), 64'(r.n));
                  chk("e_key", 64'(e_key), 64'(r.e));
                  chk("d_key", 64'(d_key), 64'(r.d));
                  if (r.err) chk("error_e_en_low", 64'(e_en), 64'd0);
                  if (r.lat >= 0) chk("timeout_latency", 64'(cyc - e_cyc), 64'(r.lat));
               end
            end
         end
         e_en_q  = e_en;
         error_q = error;
      end
   end

   task automatic kick(input logic [31:0] s);
      @(negedge clk);
      start = 1'b1;
      seed  = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_result(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done || error) begin
            seen = 1;
            break;
         end
      end
      chk({name, "_finished"}, 64'(seen), 64'd1);
   endtask

   // Expectations for a run through both multiplies.
   task automatic exp_muls(input logic [15:0] p, input logic [15:0] q);
      exp_mul.push_back({p, q});
      exp_mul.push_back({p - 16'd1, q - 16'd1});
   endtask

   task automatic exp_ok(input logic [31:0] n, input logic [31:0] e, input logic [31:0] d);
      res_t r;
      r.err = 0; r.n = n; r.e = e; r.d = d; r.lat = -1;
      exp_res.push_back(r);
   endtask

   task automatic exp_err(input int lat);
      res_t r;
      r.err = 1; r.n = '0; r.e = '0; r.d = '0; r.lat = lat;
      exp_res.push_back(r);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int used0;
      bit seen;
      repeat (3) @(negedge clk);
      chk("rst_status", {busy, done, error}, 3'b000);
      chk("rst_strobes", {prime_req, mul_start, e_en, d_start}, 4'b0000);
      chk("rst_n_key", n_key, 32'd0);
      rst = 1'b0;

      // Basic 61 x 53 key set.
      prime_q.push_back(16'd61); prime_q.push_back(16'd53);
      exp_muls(16'd61, 16'd53);
      exp_e.push_back({32'hCAFE0001, 32'd3120});
      exp_d.push_back({32'd17, 32'd3120});
      exp_ok(32'd3233, 32'd17, 32'd2753);
      used0 = prime_used;
      kick(32'hCAFE0001);
      wait_result("basic");
      chk("basic_primes_used", 64'(prime_used - used0), 64'd2);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("keys_held_n", n_key, 32'd3233);

      // Duplicate q once, then accepted.
      prime_q.push_back(16'd61); prime_q.push_back(16'd61); prime_q.push_back(16'd53);
      exp_muls(16'd61, 16'd53);
      exp_e.push_back({32'h00000002, 32'd3120});
      exp_d.push_back({32'd17, 32'd3120});
      exp_ok(32'd3233, 32'd17, 32'd2753);
      used0 = prime_used;
      kick(32'h00000002);
      wait_result("retry1");
      chk("retry1_primes_used", 64'(prime_used - used0), 64'd3);

      // Retry exhaustion.
      prime_q.push_back(16'd61); prime_q.push_back(16'd61); prime_q.push_back(16'd61);
      exp_err(-1);
      kick(32'h00000003);
      wait_result("retry_exhaust");
      repeat (5) @(negedge clk);
      chk("error_held", {error, busy}, 2'b10);

      // E engine silent: timeout from E_GEN.
      e_mute = 1;
      prime_q.push_back(16'd61); prime_q.push_back(16'd53);
      exp_muls(16'd61, 16'd53);
      exp_e.push_back({32'h00000004, 32'd3120});
      exp_err(64);
      kick(32'h00000004);
      wait_result("timeout");
      repeat (10) @(negedge clk);
      chk("timeout_error_held", {error, e_en}, 2'b10);
      e_mute = 0;

      // Restart after error, with a stray start while busy.
      prime_q.push_back(16'd61); prime_q.push_back(16'd53);
      exp_muls(16'd61, 16'd53);
      exp_e.push_back({32'h00000005, 32'd3120});
      exp_d.push_back({32'd17, 32'd3120});
      exp_ok(32'd3233, 32'd17, 32'd2753);
      kick(32'h00000005);
      chk("error_cleared_on_start", {error, busy}, 2'b01);
      repeat (8) @(negedge clk);
      chk("busy_at_stray_start", 64'(busy), 64'd1);
      start = 1'b1; seed = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0;
      wait_result("restart");

      // Reset in D_WAIT.
      d_mute = 1;
      prime_q.push_back(16'd61); prime_q.push_back(16'd53);
      exp_muls(16'd61, 16'd53);
      exp_e.push_back({32'h00000006, 32'd3120});
      exp_d.push_back({32'd17, 32'd3120});
      kick(32'h00000006);
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (d_start) begin
            seen = 1;
            break;
         end
      end
      chk("reached_d_start", 64'(seen), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_status", {busy, done, error}, 3'b000);
      chk("midrst_strobes", {prime_req, mul_start, e_en, d_start}, 4'b0000);
      chk("midrst_operands", {mul_a, mul_b, d_e}, 64'd0);
      chk("midrst_keys", {n_key, d_key}, 64'd0);
      rst = 1'b0;
      d_mute = 0;
      repeat (3) @(negedge clk);
      chk("idle_after_rst", {busy, prime_req}, 2'b00);

      // Large primes: phi = 256 * 262 = 67072.
      prime_q.push_back(16'd257); prime_q.push_back(16'd263);
      exp_muls(16'd257, 16'd263);
`ifdef KEYGEN_FIXED_E_EN
      exp_d.push_back({32'd65537, 32'd67072});
      exp_ok(32'd67591, 32'd65537, 32'd2753);
`else
      exp_e.push_back({32'h00000007, 32'd67072});
      exp_d.push_back({32'd17, 32'd67072});
      exp_ok(32'd67591, 32'd17, 32'd2753);
`endif
      kick(32'h00000007);
      wait_result("big_primes");

      repeat (4) @(negedge clk);
      chk("left_mul", 64'(exp_mul.size()), 64'd0);
      chk("left_e", 64'(exp_e.size()), 64'd0);
      chk("left_d", 64'(exp_d.size()), 64'd0);
      chk("left_res", 64'(exp_res.size()), 64'd0);
      chk("left_primes", 64'(prime_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
